r_type_pipe: RTL

Parametrised, two-stage R-type execution block: an XLEN-wide, NREG-deep register file, a combinational ALU stage and a registered write-back stage, with a valid/ready handshake on both sides. The write-back result forwards to the operand read path. It replaces the single-cycle R-type datapath and sits between instruction decode (upstream) and the commit/trace logic (downstream).

---
 rtl/r_type_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/r_type_pipe.sv
// Two-stage R-type execute block: register file + combinational ALU, registered write-back stage.
// Latency 1 cycle to out_valid; in_ready drops only while a held result is stalled by out_ready.
module r_type_pipe #(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter logic [31:0] INIT_VAL = 32'h15,
    parameter bit          ZERO_R0  = 1'b1,
    localparam int         AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [5:0]      funct,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_rd_addr,
    output logic [XLEN-1:0] out_result,
    output logic            out_carry,
    output logic            out_zero,
    output logic            out_overflow,
    output logic            out_illegal,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int              SW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] INIT_X = XLEN'(INIT_VAL);

    logic [XLEN-1:0] regs [NREG];
    logic            out_wen;
    logic            accept;
    logic            wr_en;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] alu_res;
    logic            alu_c;
    logic            alu_o;
    logic            legal;
    logic            illegal;
    logic            wen_nxt;
    logic [3:0]      op;
    logic [1:0]      mode;
    logic [SW-1:0]   shamt;

    assign op       = funct[3:0];
    assign mode     = funct[5:4];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wr_en    = out_valid && out_ready && out_wen && !(ZERO_R0 && out_rd_addr == '0);

    // The held WB result is the newest architectural value of its rd, so it bypasses the file.
    always_comb begin
        if (ZERO_R0 && rs_addr == '0)
            rs_val = '0;
        else if (out_valid && out_wen && out_rd_addr == rs_addr)
            rs_val = out_result;
        else
            rs_val = regs[rs_addr];

        if (ZERO_R0 && rt_addr == '0)
            rt_val = '0;
        else if (out_valid && out_wen && out_rd_addr == rt_addr)
            rt_val = out_result;
        else
            rt_val = regs[rt_addr];
    end

    assign shamt = rt_val[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        legal   = 1'b1;
        case (op)
            4'b0000: alu_res = rs_val & rt_val;
            4'b0001: alu_res = rs_val | rt_val;
            4'b0010: begin
                {alu_c, alu_res} = {1'b0, rs_val} + {1'b0, rt_val};
                alu_o = (rs_val[XLEN-1] == rt_val[XLEN-1]) && (alu_res[XLEN-1] != rs_val[XLEN-1]);
            end
            4'b0011: alu_res = rs_val ^ rt_val;
            4'b0100: alu_res = ~(rs_val | rt_val);
            4'b0110: begin
                {alu_c, alu_res} = {1'b0, rs_val} + {1'b0, ~rt_val} + {{XLEN{1'b0}}, 1'b1};
                alu_o = (rs_val[XLEN-1] != rt_val[XLEN-1]) && (alu_res[XLEN-1] != rs_val[XLEN-1]);
            end
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, (rs_val < rt_val)};
            4'b1001: alu_res = rs_val << shamt;
            4'b1010: alu_res = rs_val >> shamt;
            4'b1011: alu_res = $unsigned($signed(rs_val) >>> shamt);
            default: legal = 1'b0;
        endcase
        illegal = !legal || mode[1];
        if (illegal) begin
            alu_res = '0;
            alu_c   = 1'b0;
            alu_o   = 1'b0;
        end
        wen_nxt = (mode == 2'b00) && legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_wen      <= 1'b0;
            out_rd_addr  <= '0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_wen      <= wen_nxt;
            out_rd_addr  <= rd_addr;
            out_result   <= alu_res;
            out_carry    <= alu_c;
            out_zero     <= (alu_res == '0);
            out_overflow <= alu_o;
            out_illegal  <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (ZERO_R0 && i == 0) ? '0 : INIT_X;
        end else if (wr_en) begin
            regs[out_rd_addr] <= out_result;
        end
    end

    assign dbg_data = (ZERO_R0 && dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
